// File: rtl/vram_write_arbiter.sv
// rtl/vram_write_arbiter.sv - Shares the framebuffer write port between CPU pixel writes and a rectangle-fill engine.
module vram_write_arbiter #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic [18:0] cpu_addr,
    input  logic [11:0] cpu_data,
    output logic        cpu_ack,
    input  logic        fill_start,
    input  logic [9:0]  fill_x0,
    input  logic [9:0]  fill_y0,
    input  logic [9:0]  fill_x1,
    input  logic [9:0]  fill_y1,
    input  logic [11:0] fill_color,
    output logic        fill_busy,
    output logic        fill_done,
    output logic        fill_err,
    output logic [18:0] WAddr,
    output logic [11:0] Din,
    output logic        WE
);
    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam int              SW   = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   SLIM = SW'(STARVE_LIMIT);
    localparam logic [9:0]      XMAX = 10'(WIDTH - 1);
    localparam logic [9:0]      YMAX = 10'(HEIGHT - 1);
    localparam logic [18:0]     W19  = 19'(WIDTH);
    localparam logic [18:0]     YM19 = 19'(HEIGHT - 1);

    state_t        state, state_nx;
    logic [SW-1:0] starve;
    logic [9:0]    rx0, rx1, ry1, px, py;
    logic [18:0]   addr, row_base;
    logic [11:0]   color;
    logic [9:0]    cx1, cy1;
    logic [18:0]   start_addr;
    logic          reject, accept, cpu_grant, fill_grant, last_pix;

    // Framebuffer rows are stored bottom-up, so screen row y lives at row HEIGHT-1-y.
    always_comb begin
        cx1        = (fill_x1 > XMAX) ? XMAX : fill_x1;
        cy1        = (fill_y1 > YMAX) ? YMAX : fill_y1;
        reject     = (fill_x0 > cx1) || (fill_y0 > cy1) || (fill_x0 > XMAX) || (fill_y0 > YMAX);
        start_addr = W19 * (YM19 - {9'd0, fill_y0}) + {9'd0, fill_x0};
        accept     = (state == IDLE) && fill_start && !reject;
        cpu_grant  = cpu_req && ((state != FILL) || (starve < SLIM));
        fill_grant = (state == FILL) && !cpu_grant;
        last_pix   = (px == rx1) && (py == ry1);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = FILL;
            FILL:    if (fill_grant && last_pix) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign fill_busy = (state == FILL);
    assign fill_done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            starve   <= '0;
            WE       <= 1'b0;
            WAddr    <= '0;
            Din      <= '0;
            cpu_ack  <= 1'b0;
            fill_err <= 1'b0;
            rx0      <= '0;
            rx1      <= '0;
            ry1      <= '0;
            px       <= '0;
            py       <= '0;
            addr     <= '0;
            row_base <= '0;
            color    <= '0;
        end else begin
            state    <= state_nx;
            WE       <= cpu_grant || fill_grant;
            cpu_ack  <= cpu_grant;
            fill_err <= (state == IDLE) && fill_start && reject;
            if (cpu_grant) begin
                WAddr <= cpu_addr;
                Din   <= cpu_data;
            end else if (fill_grant) begin
                WAddr <= addr;
                Din   <= color;
            end
            // Starvation guard only counts while a fill is waiting for the port.
            if ((state == FILL) && cpu_grant) starve <= starve + SW'(1);
            else starve <= '0;
            if (accept) begin
                rx0      <= fill_x0;
                rx1      <= cx1;
                ry1      <= cy1;
                px       <= fill_x0;
                py       <= fill_y0;
                addr     <= start_addr;
                row_base <= start_addr;
                color    <= fill_color;
            end else if (fill_grant) begin
                if (px == rx1) begin
                    px       <= rx0;
                    py       <= py + 10'd1;
                    row_base <= row_base - W19;
                    addr     <= row_base - W19;
                end else begin
                    px   <= px + 10'd1;
                    addr <= addr + 19'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_vram_write_arbiter.sv
// tb/tb_vram_write_arbiter.sv - Scoreboard bench for vram_write_arbiter against a pixel-list reference model.
module tb_vram_write_arbiter;
    localparam int W  = 640;
    localparam int H  = 480;
    localparam int SL = 8;

    logic        clk = 1'b0, rst = 1'b1;
    logic        cpu_req = 1'b0, fill_start = 1'b0;
    logic [18:0] cpu_addr = '0;
    logic [11:0] cpu_data = '0, fill_color = '0;
    logic [9:0]  fill_x0 = '0, fill_y0 = '0, fill_x1 = '0, fill_y1 = '0;
    logic        cpu_ack, fill_busy, fill_done, fill_err, WE;
    logic [18:0] WAddr;
    logic [11:0] Din;

    vram_write_arbiter #(.WIDTH(W), .HEIGHT(H), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
        .cpu_ack(cpu_ack), .fill_start(fill_start), .fill_x0(fill_x0), .fill_y0(fill_y0),
        .fill_x1(fill_x1), .fill_y1(fill_y1), .fill_color(fill_color), .fill_busy(fill_busy),
        .fill_done(fill_done), .fill_err(fill_err), .WAddr(WAddr), .Din(Din), .WE(WE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    typedef struct {
        int cyc;
        bit we;
        int addr;
        int data;
        bit ack;
        bit done;
        bit err;
    } exp_t;

    exp_t sbq[$];
    bit   busy_exp[int];

    // Reference model: pending fill pixels as a list of linear addresses.
    int          mq[$];
    int          mstarve = 0;
    bit          mfill = 0, mdone = 0;
    logic [11:0] mcolor = '0;

    task automatic chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    function automatic void model_clear();
        mq.delete();
        mstarve = 0;
        mfill   = 0;
        mdone   = 0;
    endfunction

    // Predicts what the DUT shows in cycle cyc+1 from the inputs now applied.
    function automatic void model_step();
        exp_t e;
        bit   last, acc;
        int   cx1, cy1;
        e.cyc = cyc + 1; e.we = 0; e.addr = 0; e.data = 0; e.ack = 0; e.done = 0; e.err = 0;
        last = 0; acc = 0;
        if (rst) begin
            model_clear();
            busy_exp[cyc + 1] = 0;
            return;
        end
        if (mfill) begin
            if (cpu_req && mstarve < SL) begin
                e.we = 1; e.ack = 1; e.addr = int'(cpu_addr); e.data = int'(cpu_data);
                mstarve++;
            end else begin
                e.we = 1; e.addr = mq.pop_front(); e.data = int'(mcolor);
                mstarve = 0;
                if (mq.size() == 0) last = 1;
            end
        end else begin
            mstarve = 0;
            if (cpu_req) begin
                e.we = 1; e.ack = 1; e.addr = int'(cpu_addr); e.data = int'(cpu_data);
            end
            if (!mdone && fill_start) begin
                cx1 = (int'(fill_x1) > W - 1) ? W - 1 : int'(fill_x1);
                cy1 = (int'(fill_y1) > H - 1) ? H - 1 : int'(fill_y1);
                if (int'(fill_x0) > cx1 || int'(fill_y0) > cy1 || int'(fill_x0) >= W || int'(fill_y0) >= H)
                    e.err = 1;
                else begin
                    for (int y = int'(fill_y0); y <= cy1; y++)
                        for (int x = int'(fill_x0); x <= cx1; x++)
                            mq.push_back(W * (H - 1 - y) + x);
                    mcolor = fill_color;
                    acc = 1;
                end
            end
        end
        e.done = last;
        mdone  = last;
        mfill  = (mfill && !last) || acc;
        busy_exp[cyc + 1] = mfill;
        if (e.we || e.err) sbq.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                e = sbq.pop_front();
                chk("missing_event", 0, 1);
            end
            if (busy_exp.exists(cyc)) chk("fill_busy", fill_busy, busy_exp[cyc]);
            if (WE || fill_err || fill_done || cpu_ack) begin
                if (sbq.size() == 0 || sbq[0].cyc != cyc)
                    chk("unexpected_event", {WE, cpu_ack, fill_done, fill_err}, 0);
                else begin
                    e = sbq.pop_front();
                    if (e.we)
                        chk("write", {WE, cpu_ack, fill_done, fill_err, WAddr, Din},
                            {e.we, e.ack, e.done, e.err, 19'(e.addr), 12'(e.data)});
                    else
                        chk("flags", {WE, cpu_ack, fill_done, fill_err}, {e.we, e.ack, e.done, e.err});
                end
            end else if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                e = sbq.pop_front();
                chk("missing_event", 0, 1);
            end
        end
    end

    task automatic cyc_go(bit r, bit req);
        @(posedge clk); #1;
        rst        = r;
        cpu_req    = req;
        cpu_addr   = 19'($urandom_range(0, 307199));
        cpu_data   = 12'($urandom);
        fill_start = 1'b0;
        model_step();
    endtask

    task automatic cpu_write(logic [18:0] a, logic [11:0] d);
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = 1'b1; cpu_addr = a; cpu_data = d; fill_start = 1'b0;
        model_step();
    endtask

    task automatic start_fill(int x0, int y0, int x1, int y1, logic [11:0] c, bit req);
        @(posedge clk); #1;
        rst = 1'b0; cpu_req = req;
        cpu_addr = 19'($urandom_range(0, 307199)); cpu_data = 12'($urandom);
        fill_x0 = 10'(x0); fill_y0 = 10'(y0); fill_x1 = 10'(x1); fill_y1 = 10'(y1);
        fill_color = c; fill_start = 1'b1;
        model_step();
    endtask

    task automatic run_idle(bit held, bit rnd, int maxc);
        int n = 0;
        while ((mfill || mdone) && n < maxc) begin
            cyc_go(0, held ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0));
            n++;
        end
        chk("fill_within_bound", n < maxc, 1);
        repeat (3) cyc_go(0, 0);
    endtask

    initial begin
        int x0, y0, x1, y1;
        repeat (2) cyc_go(1, 0);
        @(negedge clk);
        chk("reset_outputs", {WE, cpu_ack, fill_busy, fill_done, fill_err, WAddr, Din}, 0);
        cyc_go(0, 0);

        cpu_write(19'h12345, 12'hABC);
        repeat (4) cyc_go(0, 0);

        start_fill(0, 0, 2, 1, 12'hF00, 0);
        run_idle(0, 0, 50);

        start_fill(0, 479, 639, 479, 12'h0F0, 1);
        run_idle(1, 0, 7000);

        start_fill(630, 10, 700, 10, 12'h00F, 0);
        run_idle(0, 0, 50);

        start_fill(5, 5, 3, 9, 12'h555, 0);
        repeat (4) cyc_go(0, 0);

        start_fill(2, 2, 4, 4, 12'h123, 0);
        repeat (3) cyc_go(0, 0);
        start_fill(100, 100, 200, 200, 12'h321, 0);
        run_idle(0, 0, 50);

        start_fill(10, 20, 13, 23, 12'h777, 0);
        repeat (4) cyc_go(0, 0);
        @(negedge clk); #1;
        chk("pre_reset_we", WE, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_outputs", {WE, cpu_ack, fill_busy, fill_done, fill_err, WAddr, Din}, 0);
        sbq.delete();
        model_clear();
        repeat (2) cyc_go(1, 0);
        repeat (3) cyc_go(0, 0);
        start_fill(10, 20, 13, 23, 12'h888, 0);
        run_idle(0, 0, 60);

        for (int i = 0; i < 8; i++) begin
            x0 = $urandom_range(1, 660);
            x1 = x0 + $urandom_range(0, 6) - 1;
            y0 = $urandom_range(470, 485);
            y1 = y0 + $urandom_range(0, 3);
            start_fill(x0, y0, x1, y1, 12'($urandom), 1'($urandom_range(0, 1)));
            run_idle(0, 1, 400);
        end

        repeat (5) cyc_go(0, 0);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
